// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types and constants for the ALU result path.
//   ALU_WIDTH      : data width of the arithmetic unit.
//   FLAG_*         : bit positions inside alu_flags_t ({Z,N,C,EQ}).
//   alu_flags_t    : packed 4-bit flag vector.
//   alu_sel_t      : packed 4-bit operation select tag.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam int FLAG_Z  = 3;
    localparam int FLAG_N  = 2;
    localparam int FLAG_C  = 1;
    localparam int FLAG_EQ = 0;

    typedef logic [3:0] alu_flags_t;
    typedef logic [3:0] alu_sel_t;

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen
// Combinational flag derivation from an arithmetic unit result. Shared with
// the branch unit.
// Ports:
//   ar_out  in  WIDTH : result word
//   cout    in  1     : carry-out
//   compare in  1     : operand equality indication
//   flags   out 4     : {Z,N,C,EQ}
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] ar_out,
    input  logic             cout,
    input  logic             compare,
    output alu_flags_t       flags
);

    always_comb begin
        flags          = '0;
        flags[FLAG_Z]  = (ar_out == '0);
        flags[FLAG_N]  = ar_out[WIDTH-1];
        flags[FLAG_C]  = cout;
        flags[FLAG_EQ] = compare;
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered output stage behind the combinational ALU. Captures result,
// derived flags and operation tag into a 2-entry skid FIFO with valid/ready
// handshake toward writeback. Optional sticky flag accumulator.
// Configuration macro: ALU_STICKY_FLAGS_EN (undefined: sticky_flags tied 0,
// clr_sticky ignored; port list unchanged).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : upstream handshake (in_ready = !rst && count != 2)
//   ar_out, cout, compare, sel : ALU result, carry, equality, operation tag
//   out_valid/out_ready : downstream handshake
//   out_data, out_flags, out_sel : head entry, zero when out_valid=0
//   clr_sticky, sticky_flags     : sticky flag clear / accumulated flags
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ar_out,
    input  logic             cout,
    input  logic             compare,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_flags,
    output logic [3:0]       out_sel,
    input  logic             clr_sticky,
    output logic [3:0]       sticky_flags
);

    alu_flags_t       flags_in;
    logic             push;
    logic             pop;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic [WIDTH-1:0] data_q  [2];
    alu_flags_t       flags_q [2];
    alu_sel_t         sel_q   [2];

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .ar_out  (ar_out),
        .cout    (cout),
        .compare (compare),
        .flags   (flags_in)
    );

    // Ready depends only on registered occupancy: no combinational path
    // from out_ready back to in_ready.
    assign in_ready  = !rst && (count != 2'd2);
    assign out_valid = !rst && (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // ---- capture stage: control state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // ---- capture stage: payload storage (not reset; masked by out_valid) ----
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr]  <= ar_out;
            flags_q[wr_ptr] <= flags_in;
            sel_q[wr_ptr]   <= sel;
        end
    end

    // ---- output stage: head mux, forced to zero when empty ----
    always_comb begin
        out_data  = '0;
        out_flags = '0;
        out_sel   = '0;
        if (out_valid) begin
            out_data  = data_q[rd_ptr];
            out_flags = flags_q[rd_ptr];
            out_sel   = sel_q[rd_ptr];
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    alu_flags_t sticky_q;

    // Clear takes effect before the OR, so clear+push yields the pushed flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (clr_sticky ? '0 : sticky_q) | (push ? flags_in : '0);
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_clr_sticky;

    assign unused_clr_sticky = clr_sticky;
    assign sticky_flags      = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ar_out;
    logic        cout;
    logic        compare;
    logic [3:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_flags;
    logic [3:0]  out_sel;
    logic        clr_sticky;
    logic [3:0]  sticky_flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ar_out       (ar_out),
        .cout         (cout),
        .compare      (compare),
        .sel          (sel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .out_sel      (out_sel),
        .clr_sticky   (clr_sticky),
        .sticky_flags (sticky_flags)
    );

    // Reference model: a bounded queue of accepted results plus sticky OR.
    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  f;
        logic [3:0]  s;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_sticky = 4'h0;

    logic [29:0] dut_vec;
    assign dut_vec = {in_ready, out_valid, out_data, out_flags, out_sel, sticky_flags};

    function automatic logic [3:0] ref_flags(logic [15:0] d, logic c, logic e);
        return {d == 16'd0, d[15], c, e};
    endfunction

    function automatic logic [29:0] exp_vec();
        ent_t       h;
        logic       v;
        logic [3:0] st;
        v = !rst && (q.size() > 0);
        h = '0;
        if (v) h = q[0];
`ifdef ALU_STICKY_FLAGS_EN
        st = m_sticky;
`else
        st = 4'h0;
`endif
        return {!rst && (q.size() < 2), v, h.d, h.f, h.s, st};
    endfunction

    // Advance one clock, updating the model with the handshake outcome.
    task automatic tick();
        ent_t e;
        bit   do_push;
        bit   do_pop;
        do_push = in_valid && !rst && (q.size() < 2);
        do_pop  = out_ready && !rst && (q.size() > 0);
        e.d = ar_out;
        e.f = ref_flags(ar_out, cout, compare);
        e.s = sel;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_sticky = 4'h0;
        end else begin
            if (do_pop) q.delete(0);
            if (do_push) q.push_back(e);
            m_sticky = (clr_sticky ? 4'h0 : m_sticky) | (do_push ? e.f : 4'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; ar_out = '0; cout = 1'b0; compare = 1'b0;
        sel = '0; out_ready = 1'b0; clr_sticky = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
            end
            checks++;
            tick();
        end
        rst = 1'b0;
        #1;
        if (dut_vec !== {1'b1, 29'd0}) begin
            failures++;
            $display("FAIL reset_idle: got %h required %h", dut_vec, {1'b1, 29'd0});
        end
        checks++;
        tick();
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle2: got %h required %h", dut_vec, exp_vec());
        end
        checks++;
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; ar_out = 16'h0000; cout = 1'b1; compare = 1'b1;
        sel = 4'b0110; out_ready = 1'b1;
        #1;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_nobypass: out_valid=%b required 0", out_valid);
        end
        checks++;
        tick();
        in_valid = 1'b0;
        #1;
        if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_flags !== 4'b1011 || out_sel !== 4'd6) begin
            failures++;
            $display("FAIL single_head: v=%b d=%h f=%b s=%0d required 1 0000 1011 6",
                     out_valid, out_data, out_flags, out_sel);
        end
        checks++;
        tick();
        if (dut_vec !== exp_vec() || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drained: got %h required %h", dut_vec, exp_vec());
        end
        checks++;
    endtask

    task automatic test_fill_stall();
        out_ready = 1'b0; cout = 1'b0; compare = 1'b0; sel = 4'h3;
        in_valid = 1'b1; ar_out = 16'h8001;
        tick();
        ar_out = 16'h0002;
        tick();
        in_valid = 1'b0;
        #1;
        if (in_ready !== 1'b0 || out_data !== 16'h8001 || out_flags !== 4'b0100) begin
            failures++;
            $display("FAIL fill_full: in_ready=%b d=%h f=%b required 0 8001 0100", in_ready, out_data, out_flags);
        end
        checks++;
        out_ready = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_noready_path: in_ready=%b required 0", in_ready);
        end
        checks++;
        tick();
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'h0002 || out_flags !== 4'b0000) begin
            failures++;
            $display("FAIL fill_second: in_ready=%b v=%b d=%h f=%b required 1 1 0002 0000",
                     in_ready, out_valid, out_data, out_flags);
        end
        checks++;
        tick();
        if (dut_vec !== exp_vec() || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fill_empty: got %h required %h", dut_vec, exp_vec());
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; cout = 1'b0; compare = 1'b0; sel = 4'h9;
        ar_out = 16'h0010;
        tick();
        for (int i = 1; i <= 20; i++) begin
            ar_out = 16'h0010 + 16'(i);
            #1;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'h0010 + 16'(i - 1)) begin
                failures++;
                $display("FAIL stream_%0d: ready=%b v=%b d=%h required 1 1 %h",
                         i, in_ready, out_valid, out_data, 16'h0010 + 16'(i - 1));
            end
            checks++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        if (out_data !== 16'h0024 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL stream_last: got %h required %h", dut_vec, exp_vec());
        end
        checks++;
        tick();
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_empty: out_valid=%b required 0", out_valid);
        end
        checks++;
    endtask

    task automatic test_sticky();
        logic [3:0] req;
        out_ready = 1'b1; in_valid = 1'b0; clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0; in_valid = 1'b1; compare = 1'b0;
        ar_out = 16'h8001; cout = 1'b0;
        tick();
        ar_out = 16'h0001; cout = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
        req = 4'b0110;
`else
        req = 4'b0000;
`endif
        #1;
        if (sticky_flags !== req) begin
            failures++;
            $display("FAIL sticky_accum: got %b required %b", sticky_flags, req);
        end
        checks++;
        clr_sticky = 1'b1; in_valid = 1'b1; ar_out = 16'h0000; cout = 1'b0;
        tick();
        clr_sticky = 1'b0; in_valid = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
        req = 4'b1000;
`else
        req = 4'b0000;
`endif
        #1;
        if (sticky_flags !== req) begin
            failures++;
            $display("FAIL sticky_clr_push: got %b required %b", sticky_flags, req);
        end
        checks++;
        tick();
        tick();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0; in_valid = 1'b1; cout = 1'b1; compare = 1'b0;
        ar_out = 16'h1234;
        tick();
        ar_out = 16'h5678;
        tick();
        in_valid = 1'b0;
        #1;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstfull_full: ready=%b v=%b required 0 1", in_ready, out_valid);
        end
        checks++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        if (dut_vec !== {1'b1, 29'd0}) begin
            failures++;
            $display("FAIL rstfull_cleared: got %h required %h", dut_vec, {1'b1, 29'd0});
        end
        checks++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 39) == 0);
            in_valid   = $urandom_range(0, 1);
            out_ready  = ($urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 9) == 0);
            ar_out     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            cout       = $urandom_range(0, 1);
            compare    = $urandom_range(0, 1);
            sel        = 4'($urandom);
            #1;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random_%0d: got %h required %h", i, dut_vec, exp_vec());
            end
            checks++;
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; clr_sticky = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_stall();
        test_back_to_back();
        test_sticky();
        test_reset_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the combinational 16-bit arithmetic/logic unit. It captures the unit's result word, carry-out and equality compare with the originating 4-bit operation select. It derives a 4-bit flag vector and buffers up to two results in a skid FIFO with a valid/ready handshake toward the writeback consumer. It breaks the combinational path from operand selection through the adder to the register file.

## Interface
Parameters:
- `WIDTH`, default 16: result data width. Must match the arithmetic unit.

Ports:
- `clk`  in  1  : single clock; all state updates on its rising edge.
- `rst`  in  1  : reset, synchronous, active-high.
- `in_valid`  in  1  : upstream result valid this cycle.
- `in_ready`  out  1  : stage can accept; equals `!rst && count != 2`.
- `ar_out`  in  WIDTH  : result word from the arithmetic unit.
- `cout`  in  1  : carry-out from the arithmetic unit.
- `compare`  in  1  : `in_a == in_b` indication.
- `sel`  in  4  : operation select that produced the result; carried as a tag.
- `out_valid`  out  1  : head entry valid.
- `out_ready`  in  1  : consumer accepts the head entry.
- `out_data`  out  WIDTH  : head result word; 0 when `out_valid=0`.
- `out_flags`  out  4  : head flags `{Z,N,C,EQ}`; 0 when `out_valid=0`.
- `out_sel`  out  4  : head operation tag; 0 when `out_valid=0`.
- `clr_sticky`  in  1  : clear the sticky flag register.
- `sticky_flags`  out  4  : OR-accumulated flags of all accepted results since the last clear.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Flags are computed at push from the inputs:
  - Z = (`ar_out == 0`)
  - N = `ar_out[WIDTH-1]`
  - C = `cout`
  - EQ = `compare`
- Each entry stores `{ar_out, flags, sel}`.
- Storage is a 2-entry circular buffer with 1-bit `wr_ptr`, 1-bit `rd_ptr` and 2-bit `count` (0..2). Both pointers wrap 1→0.
- Count update:
  - push only: count+1
  - pop only: count−1
  - push and pop together: count unchanged; both pointers advance.
- Full (count=2): `in_ready=0`, so a push cannot happen. A pop while full frees a slot, but `in_ready` rises only in the next cycle.
- Empty (count=0): `out_valid=0`. A pop is impossible. Data/flag/tag outputs are forced to 0.
- No bypass: a push into an empty buffer is visible on the outputs next cycle.
- Sticky register: each cycle `sticky <= (clr_sticky ? 0 : sticky) | (push ? flags_in : 0)`. When clear and push occur in the same cycle, the result equals the pushed flags.
- Reset mid-operation: any buffered entries are discarded. No pop is reported during or after reset.

## Timing
- Reset values:
  - `count=0`, pointers 0
  - `out_valid=0`, `out_data=0`, `out_flags=0`, `out_sel=0`
  - `sticky_flags=0`
  - `in_ready=0` while `rst` is high; `in_ready=1` in the first cycle after `rst` deasserts.
- Latency: a result accepted at edge N is presented on the outputs after edge N (visible in cycle N+1).
- Throughput: one result per cycle sustained when `out_ready` is held high.
- `in_ready` depends only on registered `count` and `rst`, never on `out_ready`. There is no combinational ready path.
- Outputs come from registered storage plus an output mux selected by `rd_ptr`/`count`. There is no combinational path from `ar_out` to the outputs.

## Configuration
- Macro: `ALU_STICKY_FLAGS_EN`.
- Defined: the sticky flag register and `clr_sticky` behave as described above.
- Undefined: the register is not instantiated. `sticky_flags` is tied to 4'b0000 and `clr_sticky` is ignored. The port list is identical in both builds.

## Structure
- Package `alu_pkg` holds:
  - flag index constants `FLAG_Z=3`, `FLAG_N=2`, `FLAG_C=1`, `FLAG_EQ=0`
  - `alu_flags_t` as packed 4 bits
  - `alu_sel_t` as packed 4 bits
  - `ALU_WIDTH=16`
- Sub-module `alu_flag_gen`: combinational, `ar_out`/`cout`/`compare` → `alu_flags_t`. The same sub-module is reused later by the branch unit.
- The FIFO and handshake logic stay in `alu_result_stage`.

## Test plan
- Reset then idle: hold `rst` 2 cycles, then release. Required: `in_ready=1`, `out_valid=0`, all outputs 0, `sticky_flags=0`.
- Single push: `ar_out=16'h0000`, `cout=1`, `compare=1`, `sel=4'b0110`, `out_ready=1`. Next cycle: `out_valid=1`, `out_data=0`, `out_flags=4'b1011`, `out_sel=6`. Following cycle: `out_valid=0`.
- Fill and stall: with `out_ready=0`, push `16'h8001` then `16'h0002`. Required: `in_ready=0` after the second push. Raising `out_ready` drains `16'h8001` (flags `4'b0100`) then `16'h0002` (flags `4'b0000`) in order. `in_ready` returns 1 the cycle after the first pop.
- Simultaneous push/pop at count=1 over 20 cycles of streaming increments starting at `16'h0010`. Required: count stays 1; outputs show the same sequence delayed one cycle; no loss or duplication; pointers wrap correctly.
- Sticky (macro defined):
  - Push N-set then C-set results → `sticky_flags=4'b0110`.
  - `clr_sticky` in the same cycle as a push of Z-set → `4'b1000`.
- Sticky (macro undefined): the same stimulus → `sticky_flags=0` throughout. Also assert `rst` while count=2 → next cycle count=0, `out_valid=0`.
